// File: rtl/div_unit.sv
// div_unit: RV32M DIV/DIVU/REM/REMU sequencer wrapped around an external unsigned divider.
// It resolves divide-by-zero and signed overflow locally and applies the sign fix-up to results.
module div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        busy,
  output logic        valid_out,
  output logic [4:0]  rd_out,
  output logic [31:0] result_out,
  output logic        div_start,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_result,
  input  logic [31:0] div_remainder,
  input  logic        div_done
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic        r_isRem;
  logic        r_negQ;
  logic        r_negR;
  logic [4:0]  r_rd;
  logic [31:0] r_result;
  logic [31:0] r_divA;
  logic [31:0] r_divB;

  logic        w_accept;
  logic        w_signed;
  logic        w_isRem;
  logic        w_divZero;
  logic        w_overflow;
  logic        w_special;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [31:0] w_specialResult;
  logic [31:0] w_quotient;
  logic [31:0] w_remainder;

  assign w_accept   = valid_in && funct3[2];
  assign w_signed   = ~funct3[0];
  assign w_isRem    = funct3[1];
  assign w_divZero  = (rs2 == 32'd0);
  assign w_overflow = w_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
  assign w_special  = w_divZero || w_overflow;

  // abs(0x80000000) wraps back to 0x80000000, which the divider treats as 2^31
  assign w_absA = (w_signed && rs1[31]) ? (32'd0 - rs1) : rs1;
  assign w_absB = (w_signed && rs2[31]) ? (32'd0 - rs2) : rs2;

  assign w_specialResult = w_divZero ? (w_isRem ? rs1 : 32'hFFFF_FFFF)
                                     : (w_isRem ? 32'd0 : 32'h8000_0000);

  assign w_quotient  = r_negQ ? (32'd0 - div_result)    : div_result;
  assign w_remainder = r_negR ? (32'd0 - div_remainder) : div_remainder;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = w_special ? RESP : START;
      START:   w_nextState = flush ? IDLE : WAIT;
      WAIT: begin
        if (flush) begin
          w_nextState = IDLE;
        end else if (div_done) begin
          w_nextState = RESP;
        end
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Operand capture on acceptance; result latched either immediately (special) or on div_done
  always_ff @(posedge clock) begin
    if (reset) begin
      r_isRem  <= 1'b0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
      r_rd     <= 5'd0;
      r_result <= 32'd0;
      r_divA   <= 32'd0;
      r_divB   <= 32'd0;
    end else begin
      if (r_state == IDLE && w_accept) begin
        r_rd    <= rd_in;
        r_isRem <= w_isRem;
        r_negQ  <= w_signed && (rs1[31] ^ rs2[31]);
        r_negR  <= w_signed && rs1[31];
        if (w_special) begin
          r_result <= w_specialResult;
        end else begin
          r_divA <= w_absA;
          r_divB <= w_absB;
        end
      end
      if (r_state == WAIT && !flush && div_done) begin
        r_result <= r_isRem ? w_remainder : w_quotient;
      end
    end
  end

  assign busy       = (r_state != IDLE);
  assign div_start  = (r_state == START);
  assign valid_out  = (r_state == RESP);
  assign result_out = valid_out ? r_result : 32'd0;
  assign rd_out     = valid_out ? r_rd : 5'd0;
  assign div_a      = r_divA;
  assign div_b      = r_divB;

endmodule
